// File: rtl/reg_pipe_pkg.sv
// rtl/reg_pipe_pkg.sv - shared sizing helpers for the reg_pipe elastic pipeline
package reg_pipe_pkg;

  // Occupancy counter width: covers 0..DEPTH+1 so the skid entry fits too.
  function automatic int count_width(input int depth);
    return $clog2(depth + 2);
  endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// rtl/reg_pipe_stage.sv - one valid/data register of the elastic pipeline (also used as skid entry)
module reg_pipe_stage #(
  parameter int             W    = 8,
  parameter logic [W-1:0]   INIT = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         load,
  input  logic         v_in,
  input  logic [W-1:0] d_in,
  output logic         v_q,
  output logic [W-1:0] d_q
);

  // Data only moves with a real beat, so an empty slot keeps its last value.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      v_q <= 1'b0;
      d_q <= INIT;
    end else if (load) begin
      v_q <= v_in;
      if (v_in) begin
        d_q <= d_in;
      end
    end
  end

endmodule

// File: rtl/reg_pipe.sv
// rtl/reg_pipe.sv - elastic register pipeline with bubble collapse
// REG_PIPE_SKID_EN: registered in_ready with one skid entry ahead of stage 0.
module reg_pipe
  import reg_pipe_pkg::*;
#(
  parameter int           W     = 8,
  parameter int           DEPTH = 2,
  parameter logic [W-1:0] INIT  = {W{1'b0}}
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [W-1:0]                    in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [W-1:0]                    out_data,
  output logic [count_width(DEPTH)-1:0]   count
);

  localparam int CW = count_width(DEPTH);

  logic [DEPTH-1:0] v;
  logic [W-1:0]     d [DEPTH];
  logic [DEPTH-1:0] adv;
  logic             s0_v;
  logic [W-1:0]     s0_d;
  logic             push;
  logic             pop;

  // A stage may load unless it and every stage downstream of it is full
  // while the output is stalled; written flat to avoid a chained vector.
  always_comb begin : adv_logic
    logic tail_full;
    tail_full = 1'b1;
    adv       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      tail_full = 1'b1;
      for (int j = i; j < DEPTH; j++) begin
        tail_full = tail_full & v[j];
      end
      adv[i] = out_ready || !tail_full;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_first
      reg_pipe_stage #(.W(W), .INIT(INIT)) u_stage (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .load  (adv[0]),
        .v_in  (s0_v),
        .d_in  (s0_d),
        .v_q   (v[0]),
        .d_q   (d[0])
      );
    end else begin : g_next
      reg_pipe_stage #(.W(W), .INIT(INIT)) u_stage (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .load  (adv[i]),
        .v_in  (v[i-1]),
        .d_in  (d[i-1]),
        .v_q   (v[i]),
        .d_q   (d[i])
      );
    end
  end

  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

`ifdef REG_PIPE_SKID_EN
  logic         skid_v;
  logic [W-1:0] skid_d;
  logic         skid_load;
  logic         skid_in_v;
  logic         ready_q;

  // Skid refills whenever it drains or is empty; it captures a new beat only
  // when that beat cannot go straight into stage 0.
  assign skid_load = !skid_v || adv[0];
  assign skid_in_v = push && (skid_v || !adv[0]);

  reg_pipe_stage #(.W(W), .INIT(INIT)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .load  (skid_load),
    .v_in  (skid_in_v),
    .d_in  (in_data),
    .v_q   (skid_v),
    .d_q   (skid_d)
  );

  // Held beat has priority over the input so ordering is preserved.
  assign s0_v = skid_v ? 1'b1   : push;
  assign s0_d = skid_v ? skid_d : in_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b0;
    end else if (flush) begin
      ready_q <= 1'b1;
    end else begin
      ready_q <= !(skid_load ? skid_in_v : skid_v);
    end
  end

  assign in_ready = ready_q;
`else
  assign s0_v     = in_valid;
  assign s0_d     = in_data;
  assign in_ready = adv[0];
`endif

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= '0;
    end else begin
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule
